// File: rtl/step_dir_out_pkg.sv
// Shared state encoding and default driver timing for the STEP/DIR output stage.
package step_dir_out_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DSETUP  = 2'd1,
    STEP_HI = 2'd2,
    STEP_LO = 2'd3
  } state_e;

  localparam int DEF_POS_W      = 32;
  localparam int DEF_PULSE_CYC  = 8;
  localparam int DEF_DIR_SETUP  = 4;
  localparam int DEF_MIN_PERIOD = 32;
  localparam int DEF_TMR_W      = 16;

endpackage

// File: rtl/step_dir_out.sv
// STEP/DIR pin generator: walks the emitted position toward target_pos one step at a
// time while honouring step high width, DIR setup time and minimum step period.
module step_dir_out
  import step_dir_out_pkg::*;
#(
  parameter int POS_W      = DEF_POS_W,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int DIR_SETUP  = DEF_DIR_SETUP,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int TMR_W      = DEF_TMR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [POS_W-1:0] target_pos,
  input  logic             load_pos,
  input  logic [POS_W-1:0] load_val,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] actual_pos,
  output logic             busy,
  output logic             at_target
);

  // Timer reload values: a phase lasting N cycles counts N-1 down to 0.
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(DIR_SETUP - 1);
  localparam logic [TMR_W-1:0] LOW_LD   = TMR_W'(MIN_PERIOD - PULSE_CYC - 1);

  state_e             state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               step_q;
  logic               dir_q;
  logic               at_target_q;
  logic [POS_W-1:0]   actual_pos_q;

  logic [POS_W-1:0]   diff;
  logic [POS_W-1:0]   pos_step_d;
  logic               need;
  logic               want_dir;
  logic               tmr_zero;
  logic               go_hi;
  logic               go_setup;
  logic               go_lo;
  logic               go_idle;

  // Wrapped difference read as signed: the MSB gives the shortest direction.
  assign diff       = target_pos - actual_pos_q;
  assign need       = enable && (diff != '0);
  assign want_dir   = ~diff[POS_W-1];
  assign tmr_zero   = (tmr_q == '0);
  assign pos_step_d = dir_q ? actual_pos_q + POS_W'(1) : actual_pos_q - POS_W'(1);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    go_hi    = 1'b0;
    go_setup = 1'b0;
    go_lo    = 1'b0;
    go_idle  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!load_pos && need) begin
          go_hi    = (dir_q == want_dir);
          go_setup = (dir_q != want_dir);
        end
      end
      DSETUP:  go_hi = tmr_zero;
      STEP_HI: go_lo = tmr_zero;
      STEP_LO: begin
        if (tmr_zero) begin
          go_hi    = need && (dir_q == want_dir);
          go_setup = need && (dir_q != want_dir);
          go_idle  = !need;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      at_target_q  <= 1'b0;
      actual_pos_q <= '0;
    end else begin
      at_target_q <= (actual_pos_q == target_pos);
      if (go_hi) begin
        state_q      <= STEP_HI;
        step_q       <= 1'b1;
        actual_pos_q <= pos_step_d;
        tmr_q        <= PULSE_LD;
      end else if (go_setup) begin
        state_q <= DSETUP;
        dir_q   <= want_dir;
        tmr_q   <= SETUP_LD;
      end else if (go_lo) begin
        state_q <= STEP_LO;
        step_q  <= 1'b0;
        tmr_q   <= LOW_LD;
      end else if (go_idle) begin
        state_q <= IDLE;
      end else begin
        // Preloads are honoured only while idle; elsewhere they are dropped.
        if (state_q == IDLE && load_pos) actual_pos_q <= load_val;
        if (!tmr_zero) tmr_q <= tmr_q - TMR_W'(1);
      end
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign actual_pos = actual_pos_q;
  assign busy       = (state_q != IDLE);
  assign at_target  = at_target_q;

endmodule

// File: tb/tb_step_dir_out.sv
// Self-checking bench for step_dir_out: timestamp-based reference model plus directed scenarios.
module tb_step_dir_out;

  localparam int POS_W = 32;
  localparam int PULSE = 4;
  localparam int DS    = 2;
  localparam int MINP  = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [POS_W-1:0] target_pos = '0;
  logic             load_pos = 1'b0;
  logic [POS_W-1:0] load_val = '0;
  logic             step, dir, busy, at_target;
  logic [POS_W-1:0] actual_pos;

  step_dir_out #(
    .POS_W(POS_W), .PULSE_CYC(PULSE), .DIR_SETUP(DS), .MIN_PERIOD(MINP), .TMR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .target_pos(target_pos),
    .load_pos(load_pos), .load_val(load_val), .step(step), .dir(dir),
    .actual_pos(actual_pos), .busy(busy), .at_target(at_target)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [POS_W-1:0] act, input logic [POS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decisions happen at edges from timestamps of the last rise
  // and of a pending post-DIR-change rise, not from a cycle counter per phase.
  int               cyc;
  int               last_rise;
  int               pending;
  logic             m_idle, m_dir, m_step, m_at;
  logic [POS_W-1:0] m_pos, m_diff;
  logic             m_need, m_want, m_rise;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc = 0; last_rise = -1000; pending = -1;
      m_idle = 1'b1; m_dir = 1'b0; m_step = 1'b0; m_at = 1'b0; m_pos = '0;
    end else begin
      cyc++;
      m_at   = (m_pos == target_pos);
      m_diff = target_pos - m_pos;
      m_need = enable && (m_diff != '0);
      m_want = ($signed(m_diff) >= 0);
      m_rise = 1'b0;
      if (pending == cyc) m_rise = 1'b1;
      else if (pending > cyc) ;
      else if (!m_idle && cyc < last_rise + MINP) ;
      else if (m_idle && load_pos) m_pos = load_val;
      else if (m_need && m_want == m_dir) m_rise = 1'b1;
      else if (m_need) begin
        m_dir = m_want; pending = cyc + DS; m_idle = 1'b0;
      end else m_idle = 1'b1;
      if (m_rise) begin
        m_pos = m_dir ? m_pos + 1 : m_pos - 1;
        last_rise = cyc; pending = -1; m_idle = 1'b0;
      end
      m_step = (cyc - last_rise) < PULSE;
    end
  end

  // Per-cycle compare plus waveform measurements used by the directed scenarios.
  int   tcyc = 0, n_rises = 0, rise_t = -1000, fall_t = -1000, last_dir_chg = -1000;
  int   last_width = 0, last_period = 0, lo_gap = 0;
  logic prev_step = 1'b0, prev_dir = 1'b0, prev_busy = 1'b0;

  always @(posedge clk) begin
    #1;
    tcyc++;
    if (rst) begin
      check("step", step, m_step);
      check("dir", dir, m_dir);
      check("actual_pos", actual_pos, m_pos);
      check("busy", busy, !m_idle);
      check("at_target", at_target, m_at);
      if (dir !== prev_dir) begin
        check("dir_change_while_step_low", prev_step, 1'b0);
        last_dir_chg = tcyc;
      end
      if (step && !prev_step) begin
        check("dir_setup_before_rise", (tcyc - last_dir_chg) >= DS, 1'b1);
        n_rises++;
        last_period = tcyc - rise_t;
        rise_t = tcyc;
      end
      if (!step && prev_step) begin
        last_width = tcyc - rise_t;
        fall_t = tcyc;
      end
      if (!busy && prev_busy) lo_gap = tcyc - fall_t;
    end else begin
      last_dir_chg = -1000;
    end
    prev_step = step; prev_dir = dir; prev_busy = busy;
  end

  task automatic wait_idle(input string name);
    int k = 0;
    repeat (2) @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic wait_step(input string name, input logic level);
    int k = 0;
    @(negedge clk);
    while (step !== level && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, "_step_timeout"}, step, level);
  endtask

  int base;

  initial begin
    // Reset values and at_target after release
    #12;
    check("rst_step", step, 1'b0);
    check("rst_dir", dir, 1'b0);
    check("rst_pos", actual_pos, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_at_target", at_target, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    check("rel_at_target", at_target, 1'b1);

    // 0 -> 3: DIR turns first, step rises two cycles later, 3 pulses at period 10
    @(negedge clk);
    base = n_rises;
    enable = 1'b1; target_pos = 32'd3;
    @(negedge clk);
    check("t2_dir", dir, 1'b1);
    check("t2_step0", step, 1'b0);
    @(negedge clk);
    check("t2_step1", step, 1'b0);
    @(negedge clk);
    check("t2_step_rise", step, 1'b1);
    check("t2_pos1", actual_pos, 32'd1);
    wait_idle("t2");
    check("t2_pos", actual_pos, 32'd3);
    check("t2_at_target", at_target, 1'b1);
    check("t2_rises", n_rises - base, 3);
    check("t2_width", last_width, PULSE);
    check("t2_period", last_period, MINP);

    // Reverse, retarget mid-pulse: the reverse pulse completes, then forward to 5
    base = n_rises;
    target_pos = 32'd0;
    wait_step("t3", 1'b1);
    check("t3_rev_pos", actual_pos, 32'd2);
    check("t3_rev_dir", dir, 1'b0);
    @(negedge clk) target_pos = 32'd5;
    wait_idle("t3");
    check("t3_pos", actual_pos, 32'd5);
    check("t3_dir", dir, 1'b1);
    check("t3_rises", n_rises - base, 4);

    // Preload near the wrap, then 0xFFFFFFFF -> 1 is two forward steps
    base = n_rises;
    load_pos = 1'b1; load_val = 32'hFFFF_FFFF; target_pos = 32'd1;
    @(negedge clk) load_pos = 1'b0;
    check("t4_loaded", actual_pos, 32'hFFFF_FFFF);
    check("t4_busy_on_load", busy, 1'b0);
    @(negedge clk);
    check("t4_first_step", step, 1'b1);
    check("t4_pos0", actual_pos, 32'h0);
    wait_idle("t4");
    check("t4_pos1", actual_pos, 32'h1);
    check("t4_rises", n_rises - base, 2);

    // enable drops in the 2nd high cycle: full 4 high, 6 low, then idle
    base = n_rises;
    target_pos = 32'd4;
    wait_step("t5", 1'b1);
    @(negedge clk) enable = 1'b0;
    wait_idle("t5");
    check("t5_width", last_width, PULSE);
    check("t5_low", lo_gap, MINP - PULSE);
    check("t5_pos", actual_pos, 32'd2);
    check("t5_rises", n_rises - base, 1);
    repeat (20) @(negedge clk);
    check("t5_still_idle", busy, 1'b0);
    check("t5_no_more", n_rises - base, 1);

    // Preload while in STEP_LO is dropped
    enable = 1'b1;
    wait_step("t6", 1'b1);
    wait_step("t6", 1'b0);
    load_pos = 1'b1; load_val = 32'h100;
    @(negedge clk) load_pos = 1'b0;
    wait_idle("t6");
    check("t6_pos", actual_pos, 32'd4);
    check("t6_at_target", at_target, 1'b1);

    // Asynchronous reset in the middle of a pulse
    target_pos = 32'd10;
    wait_step("t1", 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t1_step", step, 1'b0);
    check("t1_dir", dir, 1'b0);
    check("t1_pos", actual_pos, '0);
    check("t1_busy", busy, 1'b0);
    target_pos = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk) #1;
    check("t1_at_target", at_target, 1'b1);
    check("t1_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
